// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types: dispatch/retire bundles and sizing constants.
// The reservation station drives robDispatchStruct from this same package.
package rob_pkg;

    localparam int unsigned ROB_DEPTH  = 16;
    localparam int unsigned ROB_IDX_W  = 4;
    localparam int unsigned PHYS_REG_W = 6;
    localparam int unsigned ARCH_REG_W = 5;
    localparam int unsigned PC_W       = 32;

    typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
    typedef logic [ARCH_REG_W-1:0] arch_reg_t;
    typedef logic [PHYS_REG_W-1:0] phys_reg_t;
    typedef logic [PC_W-1:0]       pc_t;

    typedef struct packed {
        logic      valid1;
        rob_idx_t  robNum1;
        arch_reg_t destReg1;
        phys_reg_t destRegOld1;
        pc_t       pc1;
        logic      valid2;
        rob_idx_t  robNum2;
        arch_reg_t destReg2;
        phys_reg_t destRegOld2;
        pc_t       pc2;
    } robDispatchStruct;

    typedef struct packed {
        logic      valid1;
        rob_idx_t  robNum1;
        arch_reg_t destReg1;
        phys_reg_t destRegOld1;
        pc_t       pc1;
        logic      valid2;
        rob_idx_t  robNum2;
        arch_reg_t destReg2;
        phys_reg_t destRegOld2;
        pc_t       pc2;
    } robRetireStruct;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retire bundle between the pipeline (master) and the ROB (slave).
interface reorder_buffer_if;
    import rob_pkg::*;

    robDispatchStruct     robDispatch;
    logic [1:0]           cmplValid;
    rob_idx_t             cmplRob0;
    rob_idx_t             cmplRob1;
    logic [ROB_DEPTH-1:0] robFree;
    robRetireStruct       retire;
    logic [1:0]           freeRegValid;
    logic                 dispatchErr;

    modport master (
        output robDispatch,
        output cmplValid,
        output cmplRob0,
        output cmplRob1,
        input  robFree,
        input  retire,
        input  freeRegValid,
        input  dispatchErr
    );

    modport slave (
        input  robDispatch,
        input  cmplValid,
        input  cmplRob0,
        input  cmplRob1,
        output robFree,
        output retire,
        output freeRegValid,
        output dispatchErr
    );

endinterface

// File: rtl/reorder_buffer_order_queue.sv
// Program-order FIFO of ROB indices: up to two pushes and two pops per cycle.
// Callers guarantee pushes fit and pops never exceed the current count.
module rob_order_queue
    import rob_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         push_num,
    input  rob_idx_t           push_idx0,
    input  rob_idx_t           push_idx1,
    input  logic [1:0]         pop_num,
    output rob_idx_t           head_idx0,
    output rob_idx_t           head_idx1,
    output logic [ROB_IDX_W:0] count
);

    localparam rob_idx_t IDX_ONE = rob_idx_t'(1);

    rob_idx_t           mem_q [ROB_DEPTH];
    rob_idx_t           mem_d [ROB_DEPTH];
    rob_idx_t           head_q, head_d;
    rob_idx_t           tail_q, tail_d;
    logic [ROB_IDX_W:0] count_q, count_d;

    // Depth is exactly 2**ROB_IDX_W, so head/tail wrap by plain overflow.
    always_comb begin
        mem_d = mem_q;
        if (push_num != 2'd0) begin
            mem_d[tail_q] = push_idx0;
        end
        if (push_num == 2'd2) begin
            mem_d[tail_q + IDX_ONE] = push_idx1;
        end
        head_d  = head_q + {2'b00, pop_num};
        tail_d  = tail_q + {2'b00, push_num};
        count_d = count_q + {3'b000, push_num} - {3'b000, pop_num};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_idx0 = mem_q[head_q];
    assign head_idx1 = mem_q[head_q + IDX_ONE];
    assign count     = count_q;

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry reorder buffer: dual dispatch into RS-chosen slots, per-entry completion,
// and in-order dual retirement that returns old physical registers to the free list.
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH    = 16,
    parameter int unsigned RETIRE_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    reorder_buffer_if.slave  rob
);
    import rob_pkg::*;

    localparam logic [ROB_IDX_W:0] DEPTH_CNT = (ROB_IDX_W + 1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] complete_q, complete_d;
    arch_reg_t            dest_reg_q     [ROB_DEPTH];
    arch_reg_t            dest_reg_d     [ROB_DEPTH];
    phys_reg_t            dest_reg_old_q [ROB_DEPTH];
    phys_reg_t            dest_reg_old_d [ROB_DEPTH];
    pc_t                  pc_q           [ROB_DEPTH];
    pc_t                  pc_d           [ROB_DEPTH];
    robRetireStruct       retire_q, retire_d;
    logic                 dispatch_err_q, dispatch_err_d;

    robDispatchStruct        disp;
    logic                    acc1, acc2;
    logic                    ret1, ret2;
    logic [1:0]              push_num, pop_num;
    rob_idx_t                push_idx0, push_idx1;
    rob_idx_t                head_idx0, head_idx1;
    logic [ROB_IDX_W:0]      q_count;
    logic [RETIRE_WIDTH-1:0] retire_lanes;

    assign disp = rob.robDispatch;

    // Acceptance uses only registered busy/count: an entry retiring this cycle still
    // reads as busy, so a dispatch aimed at it is rejected.
    always_comb begin
        acc1 = disp.valid1 && !busy_q[disp.robNum1] && (q_count < DEPTH_CNT);
        acc2 = disp.valid2 && !busy_q[disp.robNum2]
            && !(disp.valid1 && (disp.robNum2 == disp.robNum1))
            && (({1'b0, q_count} + {5'b00000, acc1}) < {1'b0, DEPTH_CNT});

        push_num  = {1'b0, acc1} + {1'b0, acc2};
        push_idx0 = acc1 ? disp.robNum1 : disp.robNum2;
        push_idx1 = disp.robNum2;

        ret1    = (q_count != '0) && complete_q[head_idx0];
        ret2    = ret1 && (q_count >= (ROB_IDX_W + 1)'(2)) && complete_q[head_idx1];
        pop_num = {1'b0, ret1} + {1'b0, ret2};

        dispatch_err_d = (disp.valid1 && !acc1) || (disp.valid2 && !acc2);
    end

    rob_order_queue u_order_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_num  (push_num),
        .push_idx0 (push_idx0),
        .push_idx1 (push_idx1),
        .pop_num   (pop_num),
        .head_idx0 (head_idx0),
        .head_idx1 (head_idx1),
        .count     (q_count)
    );

    always_comb begin
        busy_d         = busy_q;
        complete_d     = complete_q;
        dest_reg_d     = dest_reg_q;
        dest_reg_old_d = dest_reg_old_q;
        pc_d           = pc_q;

        if (acc1) begin
            busy_d[disp.robNum1]         = 1'b1;
            complete_d[disp.robNum1]     = 1'b0;
            dest_reg_d[disp.robNum1]     = disp.destReg1;
            dest_reg_old_d[disp.robNum1] = disp.destRegOld1;
            pc_d[disp.robNum1]           = disp.pc1;
        end
        if (acc2) begin
            busy_d[disp.robNum2]         = 1'b1;
            complete_d[disp.robNum2]     = 1'b0;
            dest_reg_d[disp.robNum2]     = disp.destReg2;
            dest_reg_old_d[disp.robNum2] = disp.destRegOld2;
            pc_d[disp.robNum2]           = disp.pc2;
        end

        if (rob.cmplValid[0] && busy_q[rob.cmplRob0]) begin
            complete_d[rob.cmplRob0] = 1'b1;
        end
        if (rob.cmplValid[1] && busy_q[rob.cmplRob1]) begin
            complete_d[rob.cmplRob1] = 1'b1;
        end

        if (ret1) begin
            busy_d[head_idx0]     = 1'b0;
            complete_d[head_idx0] = 1'b0;
        end
        if (ret2) begin
            busy_d[head_idx1]     = 1'b0;
            complete_d[head_idx1] = 1'b0;
        end
    end

    always_comb begin
        retire_d = '0;
        if (ret1) begin
            retire_d.valid1      = 1'b1;
            retire_d.robNum1     = head_idx0;
            retire_d.destReg1    = dest_reg_q[head_idx0];
            retire_d.destRegOld1 = dest_reg_old_q[head_idx0];
            retire_d.pc1         = pc_q[head_idx0];
        end
        if (ret2) begin
            retire_d.valid2      = 1'b1;
            retire_d.robNum2     = head_idx1;
            retire_d.destReg2    = dest_reg_q[head_idx1];
            retire_d.destRegOld2 = dest_reg_old_q[head_idx1];
            retire_d.pc2         = pc_q[head_idx1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q         <= '0;
            complete_q     <= '0;
            dest_reg_q     <= '{default: '0};
            dest_reg_old_q <= '{default: '0};
            pc_q           <= '{default: '0};
            retire_q       <= '0;
            dispatch_err_q <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            complete_q     <= complete_d;
            dest_reg_q     <= dest_reg_d;
            dest_reg_old_q <= dest_reg_old_d;
            pc_q           <= pc_d;
            retire_q       <= retire_d;
            dispatch_err_q <= dispatch_err_d;
        end
    end

    assign retire_lanes     = {retire_q.valid2, retire_q.valid1};
    assign rob.robFree      = ~busy_q;
    assign rob.retire       = retire_q;
    assign rob.freeRegValid = retire_lanes;
    assign rob.dispatchErr  = dispatch_err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios then random traffic, all outputs compared
// every cycle against a queue-based program-order model.
module tb_reorder_buffer;
    import rob_pkg::*;

    logic        clk;
    logic        rst_n;
    int unsigned n_checks;
    int unsigned n_errors;

    reorder_buffer_if rob_if ();

    reorder_buffer #(
        .ROB_DEPTH    (16),
        .RETIRE_WIDTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (rob_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per-entry records plus an ordered list of in-flight indices.
    bit             m_busy [16];
    bit             m_comp [16];
    logic [4:0]     m_dr   [16];
    logic [5:0]     m_dro  [16];
    logic [31:0]    m_pc   [16];
    int             m_order[$];
    robRetireStruct exp_ret;
    bit             exp_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_busy[i] = 1'b0;
            m_comp[i] = 1'b0;
            m_dr[i]   = '0;
            m_dro[i]  = '0;
            m_pc[i]   = '0;
        end
        m_order.delete();
        exp_ret = '0;
        exp_err = 1'b0;
    endtask

    function automatic logic [15:0] exp_free();
        logic [15:0] f;
        for (int i = 0; i < 16; i++) f[i] = !m_busy[i];
        return f;
    endfunction

    task automatic model_step();
        robDispatchStruct d;
        robRetireStruct   r;
        bit               busy0 [16];
        bit               ok1, ok2;
        int               n_ret, idx;
        d     = rob_if.robDispatch;
        busy0 = m_busy;
        r     = '0;
        n_ret = 0;
        if (m_order.size() >= 1 && m_comp[m_order[0]]) begin
            idx = m_order[0];
            r.valid1 = 1'b1; r.robNum1 = 4'(idx); r.destReg1 = m_dr[idx];
            r.destRegOld1 = m_dro[idx]; r.pc1 = m_pc[idx];
            n_ret = 1;
            if (m_order.size() >= 2 && m_comp[m_order[1]]) begin
                idx = m_order[1];
                r.valid2 = 1'b1; r.robNum2 = 4'(idx); r.destReg2 = m_dr[idx];
                r.destRegOld2 = m_dro[idx]; r.pc2 = m_pc[idx];
                n_ret = 2;
            end
        end
        ok1 = d.valid1 && !busy0[d.robNum1] && (m_order.size() < 16);
        ok2 = d.valid2 && !busy0[d.robNum2] && !(d.valid1 && d.robNum2 == d.robNum1)
              && ((m_order.size() + int'(ok1)) < 16);
        if (rob_if.cmplValid[0] && busy0[rob_if.cmplRob0]) m_comp[rob_if.cmplRob0] = 1'b1;
        if (rob_if.cmplValid[1] && busy0[rob_if.cmplRob1]) m_comp[rob_if.cmplRob1] = 1'b1;
        repeat (n_ret) begin
            idx = m_order.pop_front();
            m_busy[idx] = 1'b0;
            m_comp[idx] = 1'b0;
        end
        if (ok1) begin
            m_busy[d.robNum1] = 1'b1; m_comp[d.robNum1] = 1'b0;
            m_dr[d.robNum1] = d.destReg1; m_dro[d.robNum1] = d.destRegOld1; m_pc[d.robNum1] = d.pc1;
            m_order.push_back(int'(d.robNum1));
        end
        if (ok2) begin
            m_busy[d.robNum2] = 1'b1; m_comp[d.robNum2] = 1'b0;
            m_dr[d.robNum2] = d.destReg2; m_dro[d.robNum2] = d.destRegOld2; m_pc[d.robNum2] = d.pc2;
            m_order.push_back(int'(d.robNum2));
        end
        exp_ret = r;
        exp_err = (d.valid1 && !ok1) || (d.valid2 && !ok2);
    endtask

    task automatic compare_outputs();
        check_eq("robFree",      rob_if.robFree,            exp_free());
        check_eq("ret_valid1",   rob_if.retire.valid1,      exp_ret.valid1);
        check_eq("ret_robNum1",  rob_if.retire.robNum1,     exp_ret.robNum1);
        check_eq("ret_destReg1", rob_if.retire.destReg1,    exp_ret.destReg1);
        check_eq("ret_oldReg1",  rob_if.retire.destRegOld1, exp_ret.destRegOld1);
        check_eq("ret_pc1",      rob_if.retire.pc1,         exp_ret.pc1);
        check_eq("ret_valid2",   rob_if.retire.valid2,      exp_ret.valid2);
        check_eq("ret_robNum2",  rob_if.retire.robNum2,     exp_ret.robNum2);
        check_eq("ret_destReg2", rob_if.retire.destReg2,    exp_ret.destReg2);
        check_eq("ret_oldReg2",  rob_if.retire.destRegOld2, exp_ret.destRegOld2);
        check_eq("ret_pc2",      rob_if.retire.pc2,         exp_ret.pc2);
        check_eq("freeRegValid", rob_if.freeRegValid,       {exp_ret.valid2, exp_ret.valid1});
        check_eq("dispatchErr",  rob_if.dispatchErr,        exp_err);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic clear_in();
        rob_if.robDispatch = '0;
        rob_if.cmplValid   = '0;
        rob_if.cmplRob0    = '0;
        rob_if.cmplRob1    = '0;
    endtask

    task automatic set_disp(input int slot, input int rob, input int dr, input int dro, input int pc);
        if (slot == 1) begin
            rob_if.robDispatch.valid1 = 1'b1; rob_if.robDispatch.robNum1 = 4'(rob);
            rob_if.robDispatch.destReg1 = 5'(dr); rob_if.robDispatch.destRegOld1 = 6'(dro);
            rob_if.robDispatch.pc1 = 32'(pc);
        end else begin
            rob_if.robDispatch.valid2 = 1'b1; rob_if.robDispatch.robNum2 = 4'(rob);
            rob_if.robDispatch.destReg2 = 5'(dr); rob_if.robDispatch.destRegOld2 = 6'(dro);
            rob_if.robDispatch.pc2 = 32'(pc);
        end
    endtask

    task automatic set_cmpl(input int lane, input int rob);
        rob_if.cmplValid[lane] = 1'b1;
        if (lane == 0) rob_if.cmplRob0 = 4'(rob);
        else           rob_if.cmplRob1 = 4'(rob);
    endtask

    // Pulses rst_n low between edges and checks the asynchronous clear before any edge.
    task automatic mid_reset(input string tag);
        clear_in();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq(tag, rob_if.robFree, 16'hFFFF);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int pairs;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear_in();
        model_reset();
        #2;
        check_eq("rst_robFree",      rob_if.robFree, 16'hFFFF);
        check_eq("rst_retire",       rob_if.retire, '0);
        check_eq("rst_freeRegValid", rob_if.freeRegValid, 2'b00);
        check_eq("rst_dispatchErr",  rob_if.dispatchErr, 1'b0);
        #10;
        rst_n = 1'b1;
        tick(); tick();

        // Basic pair: dispatch N, complete N+1, retire visible N+3.
        set_disp(1, 15, 3, 33, 'h100); set_disp(2, 14, 4, 34, 'h104); tick();
        check_eq("pair_free_busy", rob_if.robFree, 16'h3FFF);
        clear_in(); set_cmpl(0, 15); set_cmpl(1, 14); tick();
        clear_in(); tick();
        check_eq("pair_valid",  {rob_if.retire.valid1, rob_if.retire.valid2}, 2'b11);
        check_eq("pair_robNum", {rob_if.retire.robNum1, rob_if.retire.robNum2}, 8'hFE);
        check_eq("pair_oldReg", {rob_if.retire.destRegOld1, rob_if.retire.destRegOld2}, {6'd33, 6'd34});
        check_eq("pair_free",   rob_if.robFree, 16'hFFFF);

        // Younger completes first: nothing retires until the head completes.
        set_disp(1, 15, 1, 10, 'h200); set_disp(2, 14, 2, 11, 'h204); tick();
        clear_in(); set_cmpl(0, 14); tick();
        clear_in(); tick(); tick();
        check_eq("ooo_no_retire", rob_if.retire.valid1, 1'b0);
        set_cmpl(1, 15); tick();
        clear_in(); tick();
        check_eq("ooo_both",  {rob_if.retire.valid1, rob_if.retire.valid2}, 2'b11);
        check_eq("ooo_lane1", rob_if.retire.robNum1, 4'd15);

        // Head complete, second not.
        set_disp(1, 15, 5, 20, 'h300); set_disp(2, 14, 6, 21, 'h304); tick();
        clear_in(); set_cmpl(0, 15); tick();
        clear_in(); tick();
        check_eq("head_only", {rob_if.retire.valid1, rob_if.retire.valid2, rob_if.retire.robNum1}, {2'b10, 4'd15});
        set_cmpl(0, 14); tick();
        clear_in(); tick();
        check_eq("second_late", {rob_if.retire.valid1, rob_if.retire.robNum1}, {1'b1, 4'd14});

        // Dispatch to a busy entry is dropped and leaves the entry intact.
        set_disp(1, 15, 7, 40, 'h400); tick();
        clear_in(); set_disp(1, 15, 8, 41, 'h999); tick();
        check_eq("busy_err", rob_if.dispatchErr, 1'b1);
        clear_in(); tick();
        check_eq("busy_err_pulse", rob_if.dispatchErr, 1'b0);
        set_cmpl(0, 15); tick();
        clear_in(); tick();
        check_eq("busy_pc_kept", rob_if.retire.pc1, 32'h400);

        // Same robNum on both slots: slot 1 accepted, slot 2 dropped.
        set_disp(1, 7, 9, 5, 'h500); set_disp(2, 7, 10, 6, 'h504); tick();
        check_eq("dup_err",  rob_if.dispatchErr, 1'b1);
        check_eq("dup_free", rob_if.robFree, 16'hFF7F);
        clear_in(); set_cmpl(0, 7); tick();
        clear_in(); tick();
        check_eq("dup_retire", {rob_if.retire.valid1, rob_if.retire.valid2, rob_if.retire.pc1}, {2'b10, 32'h500});

        // Fill all 16, then drain in program order two per cycle.
        for (int k = 0; k < 8; k++) begin
            clear_in();
            set_disp(1, 15 - 2 * k, k, 2 * k, 'h1000 + 8 * k);
            set_disp(2, 14 - 2 * k, k + 8, 2 * k + 1, 'h1004 + 8 * k);
            tick();
        end
        check_eq("full_free", rob_if.robFree, 16'h0000);
        clear_in(); set_disp(1, 3, 0, 0, 'h2000); tick();
        check_eq("full_err", rob_if.dispatchErr, 1'b1);
        pairs = 0;
        for (int k = 0; k < 8; k++) begin
            clear_in(); set_cmpl(0, 15 - 2 * k); set_cmpl(1, 14 - 2 * k); tick();
            if (rob_if.retire.valid1 && rob_if.retire.valid2) pairs++;
        end
        clear_in();
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rob_if.retire.valid1 && rob_if.retire.valid2) pairs++;
        end
        check_eq("drain_pairs", pairs, 8);
        check_eq("drain_free", rob_if.robFree, 16'hFFFF);

        // Reset with entries in flight.
        set_disp(1, 4, 1, 1, 'h600); set_disp(2, 5, 2, 2, 'h604); tick();
        mid_reset("async_rst_free");
        tick(); tick();

        // Random traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int freeq[$];
            int busyq[$];
            int r1, r2;
            if (cyc == 700) mid_reset("rand_rst_free");
            clear_in();
            for (int i = 0; i < 16; i++) begin
                if (m_busy[i]) busyq.push_back(i);
                else           freeq.push_back(i);
            end
            r1 = (freeq.size() > 0 && $urandom_range(9) < 8) ? freeq[$urandom_range(freeq.size() - 1)]
                                                             : int'($urandom_range(15));
            r2 = (freeq.size() > 0 && $urandom_range(9) < 8) ? freeq[$urandom_range(freeq.size() - 1)]
                                                             : int'($urandom_range(15));
            if ($urandom_range(9) == 0) r2 = r1;
            if ($urandom_range(99) < 70)
                set_disp(1, r1, int'($urandom_range(31)), int'($urandom_range(63)), int'($urandom));
            if ($urandom_range(99) < 70)
                set_disp(2, r2, int'($urandom_range(31)), int'($urandom_range(63)), int'($urandom));
            for (int ln = 0; ln < 2; ln++) begin
                if ($urandom_range(99) < 60)
                    set_cmpl(ln, (busyq.size() > 0 && $urandom_range(9) < 8)
                                 ? busyq[$urandom_range(busyq.size() - 1)] : int'($urandom_range(15)));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
